// File: rtl/tracker_edit_sequencer.sv
// Tracker pattern editor sequencer: key decode, cursor tracking and VRAM
// read-modify-write through an external combinational cell controller.
//
// state  | meaning
// IDLE   | waiting for a key event; cursor moves applied here
// READ   | vram_rd_en strobe at the cursor address
// WAIT   | RD_LAT cycles of read latency; data captured on the last one
// MODIFY | cell controller sees captured word and latched action
// WRITE  | registered cell result written back to the same address
module tracker_edit_sequencer #(
  parameter int NUM_ROWS       = 32,
  parameter int NUM_CHANS      = 4,
  parameter int WORDS_PER_ROW  = 40,
  parameter int WORDS_PER_CHAN = 5,
  parameter int FIRST_ROW      = 2,
  parameter int RD_LAT         = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  keycode,
  output logic [10:0] vram_addr,
  output logic        vram_rd_en,
  input  logic [31:0] vram_rd_data,
  output logic        vram_wr_en,
  output logic [31:0] vram_wr_data,
  output logic [31:0] cell_word,
  output logic [1:0]  cell_action,
  output logic [1:0]  cell_sel,
  input  logic [31:0] cell_result,
  output logic [4:0]  cursor_row,
  output logic [1:0]  cursor_chan,
  output logic [1:0]  cursor_field,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_MODIFY, S_WRITE} state_t;

  localparam logic [4:0] ROW_MAX   = 5'(NUM_ROWS - 1);
  localparam logic [1:0] CHAN_MAX  = 2'(NUM_CHANS - 1);
  localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

  state_t     state;
  logic [7:0] prev_key;
  logic [7:0] evt_code;
  logic       evt_valid;
  logic       key_evt;
  logic [1:0] act_q;
  logic [1:0] edit_act;
  logic [1:0] wait_cnt;
  logic [1:0] chan_inc;
  logic [1:0] chan_dec;

  // Events seen while busy are dropped at detection, not queued.
  assign key_evt = (keycode != 8'h00) && (keycode != prev_key) && !busy;

  assign chan_inc = (cursor_chan == CHAN_MAX) ? 2'd0 : cursor_chan + 2'd1;
  assign chan_dec = (cursor_chan == 2'd0) ? CHAN_MAX : cursor_chan - 2'd1;

  assign vram_addr = (11'(FIRST_ROW) + 11'(cursor_row)) * 11'(WORDS_PER_ROW)
                   + 11'(cursor_chan) * 11'(WORDS_PER_CHAN) + 11'(cursor_field);
  assign cell_sel  = cursor_field;

  always_comb begin
    edit_act = 2'b00;
    case (evt_code)
      8'h2E:        edit_act = 2'b01;
      8'h2D:        edit_act = 2'b10;
      8'h4C, 8'h2A: edit_act = 2'b11;
      default:      edit_act = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      prev_key     <= 8'h00;
      evt_code     <= 8'h00;
      evt_valid    <= 1'b0;
      act_q        <= 2'b00;
      wait_cnt     <= 2'd0;
      cursor_row   <= 5'd0;
      cursor_chan  <= 2'd0;
      cursor_field <= 2'd0;
      cell_word    <= 32'h0;
      cell_action  <= 2'b00;
      vram_rd_en   <= 1'b0;
      vram_wr_en   <= 1'b0;
      vram_wr_data <= 32'h0;
      busy         <= 1'b0;
    end else begin
      prev_key    <= keycode;
      evt_valid   <= key_evt;
      evt_code    <= keycode;
      vram_rd_en  <= 1'b0;
      vram_wr_en  <= 1'b0;
      cell_action <= 2'b00;
      case (state)
        S_IDLE: begin
          if (evt_valid && edit_act != 2'b00) begin
            act_q      <= edit_act;
            vram_rd_en <= 1'b1;
            busy       <= 1'b1;
            state      <= S_READ;
          end else if (evt_valid) begin
            case (evt_code)
              8'h52: cursor_row <= (cursor_row == 5'd0) ? ROW_MAX : cursor_row - 5'd1;
              8'h51: cursor_row <= (cursor_row == ROW_MAX) ? 5'd0 : cursor_row + 5'd1;
              8'h50: begin
                if (cursor_field == 2'd0) begin
                  cursor_field <= 2'd3;
                  cursor_chan  <= chan_dec;
                end else begin
                  cursor_field <= cursor_field - 2'd1;
                end
              end
              8'h4F: begin
                if (cursor_field == 2'd3) begin
                  cursor_field <= 2'd0;
                  cursor_chan  <= chan_inc;
                end else begin
                  cursor_field <= cursor_field + 2'd1;
                end
              end
              8'h2B:   cursor_chan <= chan_inc;
              default: ;
            endcase
          end
        end
        S_READ: begin
          wait_cnt <= WAIT_LOAD;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == 2'd0) begin
            cell_word   <= vram_rd_data;
            cell_action <= act_q;
            state       <= S_MODIFY;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        S_MODIFY: begin
          vram_wr_data <= cell_result;
          vram_wr_en   <= 1'b1;
          state        <= S_WRITE;
        end
        S_WRITE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tracker_edit_sequencer.sv
// Bench for tracker_edit_sequencer: two instances (RD_LAT 2 and 4) share the
// key stimulus; each has its own VRAM model and a cycle-level reference model.
module tb_tracker_edit_sequencer;

  localparam int NI = 2;
  localparam int NR = 32;
  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  keycode = 8'h00;

  logic [10:0] vram_addr_w   [NI];
  logic        rd_en_w       [NI];
  logic        wr_en_w       [NI];
  logic [31:0] rd_data_w     [NI];
  logic [31:0] wr_data_w     [NI];
  logic [31:0] cell_word_w   [NI];
  logic [31:0] cell_result_w [NI];
  logic [1:0]  cell_action_w [NI];
  logic [1:0]  cell_sel_w    [NI];
  logic [4:0]  row_w         [NI];
  logic [1:0]  chan_w        [NI];
  logic [1:0]  field_w       [NI];
  logic        busy_w        [NI];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem  [NI][2048];
  logic [31:0] pipe [NI][4];
  int rd_cnt [NI];
  int wr_cnt [NI];

  int m_row [NI], m_chan [NI], m_field [NI], m_k [NI], m_act [NI];
  int m_prev [NI], m_pcode [NI];
  bit m_pend [NI];
  logic [31:0] m_cw [NI], m_wd [NI], m_exp_rd [NI];

  always #5 clk = ~clk;

  function automatic int lat(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  // Stand-in cell controller: inc/dec step the selected byte, delete clears it.
  function automatic logic [31:0] cell_fn(input logic [31:0] w, input logic [1:0] a,
                                          input logic [1:0] s);
    logic [31:0] unit;
    unit = 32'h1 << (8 * s);
    case (a)
      2'b01:   return w + unit;
      2'b10:   return w - unit;
      2'b11:   return w & ~(32'hFF << (8 * s));
      default: return w;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    tracker_edit_sequencer #(.RD_LAT(g == 0 ? 2 : 4)) dut (
      .clk          (clk),
      .reset        (reset),
      .keycode      (keycode),
      .vram_addr    (vram_addr_w[g]),
      .vram_rd_en   (rd_en_w[g]),
      .vram_rd_data (rd_data_w[g]),
      .vram_wr_en   (wr_en_w[g]),
      .vram_wr_data (wr_data_w[g]),
      .cell_word    (cell_word_w[g]),
      .cell_action  (cell_action_w[g]),
      .cell_sel     (cell_sel_w[g]),
      .cell_result  (cell_result_w[g]),
      .cursor_row   (row_w[g]),
      .cursor_chan  (chan_w[g]),
      .cursor_field (field_w[g]),
      .busy         (busy_w[g])
    );
    assign cell_result_w[g] = cell_fn(cell_word_w[g], cell_action_w[g], cell_sel_w[g]);
  end

  task automatic chk(input string name, input int i, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s [RD_LAT=%0d] t=%0t got 0x%0h expected 0x%0h", name, lat(i), $time, got, exp);
    end
  endtask

  function automatic int maddr(input int i);
    return (2 + m_row[i]) * 40 + m_chan[i] * 5 + m_field[i];
  endfunction

  task automatic apply_key(input int i, input int code);
    case (code)
      'h52: m_row[i] = (m_row[i] + NR - 1) % NR;
      'h51: m_row[i] = (m_row[i] + 1) % NR;
      'h50: begin
        if (m_field[i] == 0) begin m_field[i] = 3; m_chan[i] = (m_chan[i] + NC - 1) % NC; end
        else m_field[i] = m_field[i] - 1;
      end
      'h4F: begin
        if (m_field[i] == 3) begin m_field[i] = 0; m_chan[i] = (m_chan[i] + 1) % NC; end
        else m_field[i] = m_field[i] + 1;
      end
      'h2B: m_chan[i] = (m_chan[i] + 1) % NC;
      'h2E, 'h2D, 'h4C, 'h2A: begin
        m_act[i]    = (code == 'h2E) ? 1 : (code == 'h2D) ? 2 : 3;
        m_k[i]      = 1;
        m_exp_rd[i] = mem[i][maddr(i)];
      end
      default: ;
    endcase
  endtask

  // m_k counts cycles into an edit: 1 read, 2..L+1 wait, L+2 modify, L+3 write.
  task automatic model_step(input int i, input logic [7:0] kc, input logic rv);
    int  L;
    bit  det;
    if (rv) begin
      m_k[i] = 0; m_row[i] = 0; m_chan[i] = 0; m_field[i] = 0; m_act[i] = 0;
      m_prev[i] = 0; m_pend[i] = 0; m_pcode[i] = 0; m_cw[i] = 0; m_wd[i] = 0;
      return;
    end
    L   = lat(i);
    det = (kc != 0) && (int'(kc) != m_prev[i]) && (m_k[i] == 0);
    if (m_k[i] != 0) begin
      if (m_k[i] == L + 1) m_cw[i] = m_exp_rd[i];
      if (m_k[i] == L + 2) m_wd[i] = cell_fn(m_cw[i], 2'(m_act[i]), 2'(m_field[i]));
      m_k[i] = (m_k[i] == L + 3) ? 0 : m_k[i] + 1;
    end else if (m_pend[i]) begin
      apply_key(i, m_pcode[i]);
    end
    m_pend[i]  = det;
    m_pcode[i] = int'(kc);
    m_prev[i]  = int'(kc);
  endtask

  task automatic compare(input int i);
    int L, k;
    L = lat(i);
    k = m_k[i];
    chk("busy",        i, 32'(busy_w[i]),        32'(k != 0));
    chk("rd_en",       i, 32'(rd_en_w[i]),       32'(k == 1));
    chk("wr_en",       i, 32'(wr_en_w[i]),       32'(k == L + 3));
    chk("strobe_excl", i, 32'(rd_en_w[i] & wr_en_w[i]), 32'd0);
    chk("cell_action", i, 32'(cell_action_w[i]), (k == L + 2) ? 32'(m_act[i]) : 32'd0);
    chk("cell_word",   i, cell_word_w[i],        m_cw[i]);
    chk("wr_data",     i, wr_data_w[i],          m_wd[i]);
    chk("row",         i, 32'(row_w[i]),         32'(m_row[i]));
    chk("chan",        i, 32'(chan_w[i]),        32'(m_chan[i]));
    chk("field",       i, 32'(field_w[i]),       32'(m_field[i]));
    chk("cell_sel",    i, 32'(cell_sel_w[i]),    32'(m_field[i]));
    chk("vram_addr",   i, 32'(vram_addr_w[i]),   32'(maddr(i)));
  endtask

  task automatic tick(input logic [7:0] kc, input logic rv);
    logic        pr [NI];
    logic        pw [NI];
    logic [10:0] pa [NI];
    logic [31:0] pd [NI];
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      pr[i] = rd_en_w[i] && !rv;
      pw[i] = wr_en_w[i] && !rv;
      pa[i] = vram_addr_w[i];
      pd[i] = wr_data_w[i];
    end
    keycode = kc;
    reset   = rv;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      if (pw[i]) mem[i][pa[i]] = pd[i];
      for (int j = 3; j > 0; j--) pipe[i][j] = pipe[i][j-1];
      pipe[i][0]   = pr[i] ? mem[i][pa[i]] : $urandom;
      rd_data_w[i] = pipe[i][lat(i)-1];
      model_step(i, kc, rv);
      compare(i);
      if (rd_en_w[i]) rd_cnt[i]++;
      if (wr_en_w[i]) wr_cnt[i]++;
    end
  endtask

  task automatic press(input logic [7:0] kc);
    tick(kc, 1'b0);
    tick(8'h00, 1'b0);
  endtask

  task automatic do_reset();
    tick(8'h00, 1'b1);
    tick(8'h00, 1'b1);
    tick(8'h00, 1'b0);
  endtask

  logic [7:0] codes [12] = '{8'h52, 8'h51, 8'h50, 8'h4F, 8'h2B, 8'h2E,
                             8'h2D, 8'h4C, 8'h2A, 8'h04, 8'h1E, 8'h28};

  initial begin
    int rd0 [NI];
    int wr0 [NI];
    int L;
    for (int i = 0; i < NI; i++) begin
      for (int a = 0; a < 2048; a++) mem[i][a] = $urandom;
      for (int j = 0; j < 4; j++) pipe[i][j] = 32'h0;
      rd_data_w[i] = 32'h0;
      rd_cnt[i] = 0;
      wr_cnt[i] = 0;
      model_step(i, 8'h00, 1'b1);
    end

    do_reset();
    for (int i = 0; i < NI; i++) begin
      chk("reset_addr",  i, 32'(vram_addr_w[i]), 32'd80);
      chk("reset_busy",  i, 32'(busy_w[i]),      32'd0);
      chk("reset_wdata", i, wr_data_w[i],        32'h0);
    end

    // Cursor navigation: row 3, chan 2, field 3.
    repeat (3) press(8'h51);
    repeat (3) press(8'h4F);
    repeat (2) press(8'h2B);
    for (int i = 0; i < NI; i++) begin
      chk("nav_row",  i, 32'(row_w[i]),       32'd3);
      chk("nav_chan", i, 32'(chan_w[i]),      32'd2);
      chk("nav_fld",  i, 32'(field_w[i]),     32'd3);
      chk("nav_addr", i, 32'(vram_addr_w[i]), 32'h0D5);
    end

    // Backward wrap from the origin.
    do_reset();
    press(8'h52);
    press(8'h50);
    for (int i = 0; i < NI; i++) begin
      chk("wrap_row",  i, 32'(row_w[i]),   32'd31);
      chk("wrap_chan", i, 32'(chan_w[i]),  32'd3);
      chk("wrap_fld",  i, 32'(field_w[i]), 32'd3);
    end

    // Increment on the octave field: exact pipeline timing.
    do_reset();
    press(8'h4F);
    for (int i = 0; i < NI; i++) mem[i][81] = 32'h0000_3400;
    tick(8'h2E, 1'b0);
    for (int s = 1; s <= 8; s++) begin
      tick(8'h00, 1'b0);
      for (int i = 0; i < NI; i++) begin
        L = lat(i);
        chk("inc_rd_en", i, 32'(rd_en_w[i]), 32'(s == 1));
        chk("inc_wr_en", i, 32'(wr_en_w[i]), 32'(s == L + 3));
        chk("inc_busy",  i, 32'(busy_w[i]),  32'(s <= L + 3));
        if (s == L + 2) begin
          chk("inc_action", i, 32'(cell_action_w[i]), 32'd1);
          chk("inc_sel",    i, 32'(cell_sel_w[i]),    32'd1);
        end
        if (s == L + 3) chk("inc_wdata", i, wr_data_w[i], 32'h0000_3500);
      end
    end
    for (int i = 0; i < NI; i++) chk("inc_mem", i, mem[i][81], 32'h0000_3500);

    // Held delete key: exactly one RMW.
    for (int i = 0; i < NI; i++) rd0[i] = rd_cnt[i];
    repeat (10) tick(8'h4C, 1'b0);
    repeat (8) tick(8'h00, 1'b0);
    for (int i = 0; i < NI; i++) begin
      chk("hold_rmw_cnt", i, 32'(rd_cnt[i] - rd0[i]), 32'd1);
      chk("hold_del_mem", i, mem[i][81], 32'h0);
    end

    // Decrement pressed while busy must be dropped.
    for (int i = 0; i < NI; i++) rd0[i] = rd_cnt[i];
    tick(8'h2E, 1'b0);
    tick(8'h00, 1'b0);
    tick(8'h2D, 1'b0);
    repeat (8) tick(8'h00, 1'b0);
    for (int i = 0; i < NI; i++) begin
      chk("busy_drop_cnt", i, 32'(rd_cnt[i] - rd0[i]), 32'd1);
      chk("busy_drop_mem", i, mem[i][81], 32'h0000_0100);
    end

    // Reset during WAIT aborts with no write.
    for (int i = 0; i < NI; i++) wr0[i] = wr_cnt[i];
    tick(8'h2E, 1'b0);
    tick(8'h00, 1'b0);
    tick(8'h00, 1'b0);
    tick(8'h00, 1'b1);
    for (int i = 0; i < NI; i++) begin
      chk("abort_busy",  i, 32'(busy_w[i]),  32'd0);
      chk("abort_field", i, 32'(field_w[i]), 32'd0);
    end
    tick(8'h00, 1'b1);
    repeat (8) tick(8'h00, 1'b0);
    for (int i = 0; i < NI; i++) begin
      chk("abort_no_wr", i, 32'(wr_cnt[i] - wr0[i]), 32'd0);
      chk("abort_mem",   i, mem[i][81], 32'h0000_0100);
    end

    // Key held across reset release fires once.
    tick(8'h51, 1'b1);
    tick(8'h51, 1'b1);
    repeat (5) tick(8'h51, 1'b0);
    for (int i = 0; i < NI; i++) chk("held_release_row", i, 32'(row_w[i]), 32'd1);
    tick(8'h00, 1'b0);

    // Randomized key sequences with occasional resets.
    repeat (500) begin
      logic [7:0] kc;
      kc = ($urandom_range(0, 9) == 0) ? 8'($urandom) : codes[$urandom_range(0, 11)];
      repeat ($urandom_range(1, 4)) tick(kc, 1'b0);
      repeat ($urandom_range(1, 3)) tick(8'h00, 1'b0);
      if ($urandom_range(0, 59) == 0) begin
        repeat ($urandom_range(1, 2)) tick(8'h00, 1'b1);
      end
    end
    repeat (10) tick(8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
